fetch_line_selector: RTL and testbench

//  Fetch stage between I-cache and decode. Requests lines from the I-cache.

---
 rtl/mmm_pkg.sv | 47 ++++
 rtl/fetch_line_selector_instr_extract.sv | 22 ++
 rtl/fetch_line_selector.sv | 170 +++++++++++++++++
 tb/tb_fetch_line_selector.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared fetch-path types, widths and helpers for the mmm core.
// Latency: none (constants, types and pure functions only).
// Backpressure: none.
package mmm_pkg;

  // Core widths. OFFSET is the byte offset inside one instruction and
  // ICACHE_OFFSET is the instruction index inside one I-cache line.
  localparam int ILEN            = 8;
  localparam int XLEN            = 16;
  localparam int ICACHE_INSTR    = 4;
  localparam int OFFSET          = $clog2(ILEN / 8);
  localparam int ICACHE_OFFSET   = $clog2(ICACHE_INSTR);
  localparam int ICACHE_LINE_LEN = ICACHE_INSTR * ILEN;

  // Byte strides for PC arithmetic.
  localparam int LINE_BYTES  = ICACHE_INSTR * (ILEN / 8);
  localparam int INSTR_BYTES = ILEN / 8;

  localparam logic [XLEN-1:0] BOOT_PC = '0;
  localparam logic [ILEN-1:0] NOP     = ILEN'(8'h13);

  // One I-cache response: line address plus the whole line.
  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [ICACHE_LINE_LEN-1:0] line;
  } icache_out_t;

  // Where line_reg is reloaded from on a given cycle.
  typedef enum logic [1:0] {
    SRC_CACHE_OUT,
    SRC_LINE_REG,
    SRC_LINE_BAK
  } line_src_t;

  // Number of valid line buffers held by the fetch stage.
  typedef enum logic [1:0] {
    FS_EMPTY,
    FS_ONE,
    FS_TWO
  } fetch_state_t;

  // Clear the in-line offset bits so the address names a whole line.
  function automatic logic [XLEN-1:0] line_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_line_selector_instr_extract.sv
// Picks one instruction out of a cache line by its in-line index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the result.
module instr_extract
  import mmm_pkg::*;
(
  input  logic [ICACHE_LINE_LEN-1:0] line,
  input  logic [ICACHE_OFFSET-1:0]   idx,
  output logic [ILEN-1:0]            instr
);

  // Index mux: slot 0 sits in the least significant bits of the line.
  always_comb begin
    instr = '0;
    for (int i = 0; i < ICACHE_INSTR; i++) begin
      if (idx == ICACHE_OFFSET'(i)) begin
        instr = line[i*ILEN +: ILEN];
      end
    end
  end

endmodule

// File: rtl/fetch_line_selector.sv
// Fetch stage: requests I-cache lines, double-buffers them, hands decode one instr/cycle.
// Latency: first instr two cycles after a granted request with a 1-cycle cache; no bubble across lines.
// Backpressure: decode stall freezes pc and buffers; a full second buffer stops requests and responses.
module fetch_line_selector
  import mmm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              fetch_req_o,
  output logic [XLEN-1:0]   fetch_pc_o,
  input  logic              fetch_gnt_i,
  input  logic              icache_valid_i,
  output logic              icache_ready_o,
  input  icache_out_t       icache_out_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [ILEN-1:0]   instr_o,
  output logic [XLEN-1:0]   instr_pc_o
);

  localparam logic [XLEN-1:0]          LINE_STEP  = XLEN'(LINE_BYTES);
  localparam logic [XLEN-1:0]          INSTR_STEP = XLEN'(INSTR_BYTES);
  localparam logic [ICACHE_OFFSET-1:0] LAST_IDX   = ICACHE_OFFSET'(ICACHE_INSTR - 1);

  // Architectural state.
  fetch_state_t               state_q, state_d;
  logic [XLEN-1:0]            pc_q, pc_d;             // PC of the instr offered to decode
  logic [XLEN-1:0]            fetch_pc_q, fetch_pc_d; // next line address to request
  logic [XLEN-1:0]            exp_pc_q, exp_pc_d;     // line address of the outstanding request
  logic                       outstanding_q, outstanding_d;
  logic                       stale_q, stale_d;       // outstanding response predates a flush
  logic [ICACHE_LINE_LEN-1:0] line_reg_q, line_reg_d;
  logic [ICACHE_LINE_LEN-1:0] line_bak_q, line_bak_d;

  // Per-cycle events.
  logic                       req_fire;
  logic                       resp_fire;
  logic                       resp_good;
  logic                       instr_fire;
  logic                       line_last;
  logic [ICACHE_OFFSET-1:0]   idx;
  logic [ILEN-1:0]            extracted;
  line_src_t                  line_src;

  assign idx       = pc_q[OFFSET+ICACHE_OFFSET-1:OFFSET];
  assign line_last = (idx == LAST_IDX);

  // Only one request may be in flight, and never while both buffers are full;
  // the reset gate keeps the request low while stale state is still visible.
  assign fetch_req_o    = rst_n_i && !outstanding_q && (state_q != FS_TWO) && !flush_i;
  assign fetch_pc_o     = fetch_pc_q;
  assign icache_ready_o = outstanding_q && (state_q != FS_TWO);

  assign req_fire   = fetch_req_o && fetch_gnt_i;
  assign resp_fire  = icache_valid_i && icache_ready_o;
  // A response is only usable if it answers the request we still care about.
  assign resp_good  = resp_fire && !stale_q && (icache_out_i.pc == exp_pc_q);

  assign instr_valid_o = (state_q != FS_EMPTY) && !flush_i;
  assign instr_fire    = instr_valid_o && instr_ready_i;
  assign instr_pc_o    = pc_q;
  assign instr_o       = (state_q == FS_EMPTY) ? NOP : extracted;

  instr_extract u_instr_extract (
    .line  (line_reg_q),
    .idx   (idx),
    .instr (extracted)
  );

  // Next-state: request bookkeeping, buffer occupancy, pc advance and flush override.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    exp_pc_d      = exp_pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    line_bak_d    = line_bak_q;
    line_reg_d    = line_reg_q;
    line_src      = SRC_LINE_REG;

    // Request and response handshakes are mutually exclusive by construction.
    if (req_fire) begin
      outstanding_d = 1'b1;
      exp_pc_d      = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + LINE_STEP;
    end
    if (resp_fire) begin
      outstanding_d = 1'b0;
      stale_d       = 1'b0;
    end

    if (flush_i) begin
      // Redirect wins: buffers are discarded and any in-flight line is marked
      // stale unless it is being swallowed this very cycle.
      pc_d       = redirect_pc_i;
      state_d    = FS_EMPTY;
      fetch_pc_d = line_align(redirect_pc_i);
      stale_d    = outstanding_q && !resp_fire;
    end else begin
      if (instr_fire) begin
        pc_d = pc_q + INSTR_STEP;
      end

      case (state_q)
        FS_EMPTY: begin
          if (resp_good) begin
            state_d  = FS_ONE;
            line_src = SRC_CACHE_OUT;
          end
        end
        FS_ONE: begin
          if (instr_fire && line_last) begin
            // Current line used up; a line arriving now replaces it directly.
            if (resp_good) begin
              line_src = SRC_CACHE_OUT;
            end else begin
              state_d = FS_EMPTY;
            end
          end else if (resp_good) begin
            state_d    = FS_TWO;
            line_bak_d = icache_out_i.line;
          end
        end
        FS_TWO: begin
          // No response can land here: the cache is held off while full.
          if (instr_fire && line_last) begin
            state_d  = FS_ONE;
            line_src = SRC_LINE_BAK;
          end
        end
        default: begin
          state_d = FS_EMPTY;
        end
      endcase
    end

    case (line_src)
      SRC_CACHE_OUT: line_reg_d = icache_out_i.line;
      SRC_LINE_BAK:  line_reg_d = line_bak_q;
      default:       line_reg_d = line_reg_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= FS_EMPTY;
      pc_q          <= BOOT_PC;
      fetch_pc_q    <= line_align(BOOT_PC);
      exp_pc_q      <= line_align(BOOT_PC);
      outstanding_q <= 1'b0;
      stale_q       <= 1'b0;
      line_reg_q    <= '0;
      line_bak_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      exp_pc_q      <= exp_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      line_reg_q    <= line_reg_d;
      line_bak_q    <= line_bak_d;
    end
  end

endmodule

// File: tb/tb_fetch_line_selector.sv
// Bench for fetch_line_selector: directed scenarios followed by a random phase.
// A 1-cycle I-cache model answers each grant; a stream model predicts every decoded instr.
// Decode ready, grant, response hold and flushes are randomised in the second phase.
module tb_fetch_line_selector;
  import mmm_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            fetch_req;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_gnt = 1'b1;
  logic            icache_valid;
  logic            icache_ready;
  icache_out_t     icache_out;
  logic            instr_valid;
  logic            instr_ready = 1'b1;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  int n_checks = 0;
  int n_errors = 0;
  int n_fired  = 0;

  // Cache model controls.
  logic            hold_rsp = 1'b0;
  logic            bogus_en = 1'b0;
  logic            rsp_pend = 1'b0;
  logic [XLEN-1:0] rsp_pc   = '0;

  always #5 clk = ~clk;

  fetch_line_selector dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .flush_i        (flush),
    .redirect_pc_i  (redirect_pc),
    .fetch_req_o    (fetch_req),
    .fetch_pc_o     (fetch_pc),
    .fetch_gnt_i    (fetch_gnt),
    .icache_valid_i (icache_valid),
    .icache_ready_o (icache_ready),
    .icache_out_i   (icache_out),
    .instr_valid_o  (instr_valid),
    .instr_ready_i  (instr_ready),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc)
  );

  // Program memory: byte address -> instruction, e.g. 'h0..'h3 hold 'h10..'h13.
  function automatic logic [ILEN-1:0] mem(input logic [XLEN-1:0] a);
    return (a[7:0] + 8'h10) ^ a[15:8];
  endfunction

  function automatic logic [ICACHE_LINE_LEN-1:0] mk_line(input logic [XLEN-1:0] a);
    logic [ICACHE_LINE_LEN-1:0] l;
    l = '0;
    for (int i = 0; i < ICACHE_INSTR; i++) l[i*ILEN +: ILEN] = mem(a + XLEN'(i));
    return l;
  endfunction

  // I-cache: answer each granted request one cycle later, optionally held or misaddressed.
  always @(posedge clk) begin
    if (!rst_n) begin
      rsp_pend <= 1'b0;
    end else begin
      if (icache_valid && icache_ready) rsp_pend <= 1'b0;
      if (fetch_req && fetch_gnt) begin
        rsp_pend <= 1'b1;
        rsp_pc   <= (bogus_en && fetch_pc == 16'h0004) ? 16'h0020 : fetch_pc;
      end
    end
  end
  assign icache_valid = rsp_pend && !hold_rsp;
  assign icache_out   = {rsp_pc, mk_line(rsp_pc)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Stream model: decode must see consecutive PCs from the last reset/redirect,
  // each carrying the instruction stored at that address.
  logic [XLEN-1:0] exp_pc = BOOT_PC;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc <= BOOT_PC;
    end else if (flush) begin
      exp_pc <= redirect_pc;
    end else if (instr_valid && instr_ready) begin
      chk("stream_pc", 32'(instr_pc), 32'(exp_pc));
      chk("stream_instr", 32'(instr), 32'(mem(exp_pc)));
      exp_pc  <= exp_pc + 16'd1;
      n_fired <= n_fired + 1;
    end
    if (rst_n && fetch_req) chk("one_outstanding", 32'(rsp_pend), 32'd0);
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Returns at the negedge of the cycle offering instr at target (bounded).
  task automatic wait_pc(input string tag, input logic [XLEN-1:0] target, input int max_cyc);
    bit found;
    found = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      smp();
      if (instr_valid && instr_pc == target) begin
        found = 1'b1;
        break;
      end
      drv();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Returns at the negedge of the cycle requesting line target (bounded).
  task automatic wait_req(input string tag, input logic [XLEN-1:0] target, input int max_cyc);
    bit found;
    found = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      smp();
      if (fetch_req && fetch_pc == target) begin
        found = 1'b1;
        break;
      end
      drv();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    int fired_before;
    // Reset values while reset is held.
    repeat (3) drv();
    smp();
    chk("rst_req", 32'(fetch_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'(NOP));
    chk("rst_fetch_pc", 32'(fetch_pc), 32'h0);

    // 1: boot, first request right after release, then 0..4 with no bubble.
    drv(); rst_n = 1'b1;
    smp();
    chk("boot_req", 32'(fetch_req), 32'd1);
    chk("boot_fetch_pc", 32'(fetch_pc), 32'h0);
    chk("boot_valid", 32'(instr_valid), 32'd0);
    drv();
    smp();
    chk("boot_rsp_ready", 32'(icache_ready), 32'd1);
    chk("boot_valid2", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drv();
      smp();
      chk("seq_valid", 32'(instr_valid), 32'd1);
      chk("seq_pc", 32'(instr_pc), 32'(i));
      chk("seq_instr", 32'(instr), 32'h10 + 32'(i));
    end

    // 2: decode stall at pc 6 while the next line fills the second buffer.
    drv();
    drv(); instr_ready = 1'b0;
    smp();
    chk("stall_pc0", 32'(instr_pc), 32'h6);
    for (int i = 0; i < 5; i++) begin
      drv();
      smp();
      chk("stall_pc", 32'(instr_pc), 32'h6);
      chk("stall_instr", 32'(instr), 32'h16);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_two_noreq", 32'(fetch_req), 32'd0);
      chk("stall_two_nordy", 32'(icache_ready), 32'd0);
    end
    drv(); instr_ready = 1'b1;

    // 3: flush to 'h0A with a request in flight whose response is delayed.
    wait_req("pre_flush_req", 16'h000C, 8);
    drv(); flush = 1'b1; redirect_pc = 16'h000A; hold_rsp = 1'b1;
    smp();
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_noreq", 32'(fetch_req), 32'd0);
    drv(); flush = 1'b0;
    smp();
    chk("stale_wait_noreq", 32'(fetch_req), 32'd0);
    drv(); hold_rsp = 1'b0;
    smp();
    chk("stale_accept", 32'(icache_ready), 32'd1);
    chk("stale_valid", 32'(instr_valid), 32'd0);
    drv();
    smp();
    chk("reissue_req", 32'(fetch_req), 32'd1);
    chk("reissue_pc", 32'(fetch_pc), 32'h8);
    chk("stale_dropped", 32'(instr_valid), 32'd0);
    wait_pc("redirect_first", 16'h000A, 4);
    chk("redirect_instr", 32'(instr), 32'h1A);

    // 4: response for 'h20 while 'h4 is expected is dropped.
    drv(); flush = 1'b1; redirect_pc = 16'h0000; instr_ready = 1'b0; bogus_en = 1'b1;
    smp();
    chk("f4_valid", 32'(instr_valid), 32'd0);
    drv(); flush = 1'b0;
    wait_req("bogus_req", 16'h0004, 8);
    drv();
    smp();
    chk("bogus_taken", 32'(icache_ready), 32'd1);
    chk("bogus_pc_before", 32'(instr_pc), 32'h0);
    drv();
    smp();
    chk("bogus_valid", 32'(instr_valid), 32'd1);
    chk("bogus_pc", 32'(instr_pc), 32'h0);
    chk("bogus_instr", 32'(instr), 32'h10);
    chk("bogus_req_again", 32'(fetch_req), 32'd1);
    chk("bogus_fetch_pc", 32'(fetch_pc), 32'h8);

    // 5: redirect near the top of the address space and wrap to 0.
    drv(); flush = 1'b1; redirect_pc = 16'hFFFC; instr_ready = 1'b1; bogus_en = 1'b0;
    smp();
    chk("f5_valid", 32'(instr_valid), 32'd0);
    drv(); flush = 1'b0;
    smp();
    chk("wrap_req", 32'(fetch_req), 32'd1);
    chk("wrap_req_pc", 32'(fetch_pc), 32'hFFFC);
    wait_pc("wrap_first", 16'hFFFC, 6);
    chk("wrap_first_instr", 32'(instr), 32'hF3);
    chk("wrap_next_req", 32'(fetch_req), 32'd1);
    chk("wrap_next_pc", 32'(fetch_pc), 32'h0);
    wait_pc("wrap_zero", 16'h0000, 8);
    chk("wrap_zero_instr", 32'(instr), 32'h10);

    // 6: reset with both buffers full.
    drv(); instr_ready = 1'b0;
    drv();
    smp();
    chk("two_noreq", 32'(fetch_req), 32'd0);
    chk("two_nordy", 32'(icache_ready), 32'd0);
    chk("two_valid", 32'(instr_valid), 32'd1);
    drv(); rst_n = 1'b0;
    smp();
    chk("mid_rst_noreq", 32'(fetch_req), 32'd0);
    drv();
    smp();
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", 32'(instr), 32'(NOP));
    chk("mid_rst_pc", 32'(instr_pc), 32'h0);
    chk("mid_rst_fetch_pc", 32'(fetch_pc), 32'h0);
    drv(); rst_n = 1'b1; instr_ready = 1'b1;
    smp();
    chk("post_rst_req", 32'(fetch_req), 32'd1);

    // Random phase: stalls, grant gaps, slow responses and redirects.
    fired_before = n_fired;
    for (int c = 0; c < 3000; c++) begin
      drv();
      instr_ready = ($urandom_range(0, 99) < 70);
      fetch_gnt   = ($urandom_range(0, 99) < 80);
      hold_rsp    = ($urandom_range(0, 99) < 25);
      flush       = ($urandom_range(0, 99) < 3);
      redirect_pc = 16'($urandom);
    end
    drv(); flush = 1'b0; instr_ready = 1'b1; fetch_gnt = 1'b1; hold_rsp = 1'b0;
    repeat (4) drv();
    smp();
    chk("random_progress", 32'(n_fired - fired_before > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
